floo_perf_monitor: RTL and testbench

- Synthesizable, multi-port, windowed traffic monitor for FlooNoC endpoints. Successor to the simulation-only AXI bandwidth monitor.
- For each of NumPorts monitored AXI interfaces it counts read and write beats per measurement window, tracks outstanding transactions, and accumulates read latency using Little's law (in-flight integral).
- Supports single-shot and back-to-back continuous windows.
- Sits beside chimneys or cluster ports. Snapshots are read through a port-select mux.

---
 rtl/floo_pkg.sv | 25 ++
 rtl/floo_perf_port_cnt.sv | 183 ++++++++++++++++++
 rtl/floo_perf_monitor.sv | 164 ++++++++++++++++
 tb/tb_floo_perf_monitor.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/floo_pkg.sv
// Shared types and default widths for the FlooNoC performance monitor.
// perf_state_e encodes the measurement FSM; perf_cnt_t bundles one snapshot.
package floo_pkg;

    localparam int unsigned DefNumPorts    = 4;
    localparam int unsigned DefCntWidth    = 32;
    localparam int unsigned DefWindowWidth = 16;
    localparam int unsigned DefMaxInFlight = 16;
    localparam int unsigned DefInfWidth    = $clog2(DefMaxInFlight + 1);

    typedef enum logic [1:0] {
        PerfIdle = 2'd0,
        PerfRun  = 2'd1,
        PerfHold = 2'd2
    } perf_state_e;

    typedef struct packed {
        logic [DefCntWidth-1:0] rd_beats;
        logic [DefCntWidth-1:0] wr_beats;
        logic [DefCntWidth-1:0] rd_txns;
        logic [DefCntWidth-1:0] rd_lat_sum;
        logic [DefInfWidth-1:0] max_rd_inf;
    } perf_cnt_t;

endpackage

// File: rtl/floo_perf_port_cnt.sv
// Per-port counters: in-flight trackers, active window counters, snapshots.
// Inputs: run/clear/snapshot strobes from the FSM plus AXI handshake events.
// Outputs: snapshot values and sticky overflow/error flags for this port.
module floo_perf_port_cnt
    import floo_pkg::*;
#(
    parameter int unsigned CntWidth    = DefCntWidth,
    parameter int unsigned MaxInFlight = DefMaxInFlight,
    localparam int unsigned InfWidth   = $clog2(MaxInFlight + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                run_i,
    input  logic                clr_i,
    input  logic                flag_clr_i,
    input  logic                snap_i,
    input  logic                rd_req_i,
    input  logic                rd_beat_i,
    input  logic                rd_last_i,
    input  logic                wr_req_i,
    input  logic                wr_beat_i,
    input  logic                wr_done_i,
    output logic [CntWidth-1:0] snap_rd_beats_o,
    output logic [CntWidth-1:0] snap_wr_beats_o,
    output logic [CntWidth-1:0] snap_rd_txns_o,
    output logic [CntWidth-1:0] snap_rd_lat_sum_o,
    output logic [InfWidth-1:0] snap_max_rd_inf_o,
    output logic                overflow_o,
    output logic                error_o
);

    localparam logic [InfWidth-1:0] InfMax = InfWidth'(MaxInFlight);

    logic [InfWidth-1:0] rd_inf_q, rd_inf_d;
    logic [InfWidth-1:0] wr_inf_q, wr_inf_d;
    logic [CntWidth-1:0] rd_beats_q, rd_beats_d;
    logic [CntWidth-1:0] wr_beats_q, wr_beats_d;
    logic [CntWidth-1:0] rd_txns_q, rd_txns_d;
    logic [CntWidth-1:0] rd_lat_q, rd_lat_d;
    logic [InfWidth-1:0] max_inf_q, max_inf_d;
    logic [CntWidth-1:0] s_rd_beats_q, s_rd_beats_d;
    logic [CntWidth-1:0] s_wr_beats_q, s_wr_beats_d;
    logic [CntWidth-1:0] s_rd_txns_q, s_rd_txns_d;
    logic [CntWidth-1:0] s_rd_lat_q, s_rd_lat_d;
    logic [InfWidth-1:0] s_max_inf_q, s_max_inf_d;
    logic                overflow_q, overflow_d;
    logic                error_q, error_d;

    logic [CntWidth:0]   rd_beats_upd, wr_beats_upd, rd_txns_upd, rd_lat_upd;
    logic [InfWidth-1:0] max_inf_upd;
    logic                rd_err, wr_err, ovf_evt;

    // MSB of the result flags saturation; low bits hold the clamped sum.
    function automatic logic [CntWidth:0] sat_add(
        input logic [CntWidth-1:0] a,
        input logic [CntWidth-1:0] b
    );
        logic [CntWidth:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[CntWidth]) begin
            s = {1'b1, {CntWidth{1'b1}}};
        end
        return s;
    endfunction

    always_comb begin
        rd_inf_d = rd_inf_q;
        rd_err   = 1'b0;
        unique case ({rd_req_i, rd_last_i})
            2'b10: begin
                if (rd_inf_q == InfMax) rd_err = 1'b1;
                else rd_inf_d = rd_inf_q + 1'b1;
            end
            2'b01: begin
                if (rd_inf_q == '0) rd_err = 1'b1;
                else rd_inf_d = rd_inf_q - 1'b1;
            end
            default: ;
        endcase

        wr_inf_d = wr_inf_q;
        wr_err   = 1'b0;
        unique case ({wr_req_i, wr_done_i})
            2'b10: begin
                if (wr_inf_q == InfMax) wr_err = 1'b1;
                else wr_inf_d = wr_inf_q + 1'b1;
            end
            2'b01: begin
                if (wr_inf_q == '0) wr_err = 1'b1;
                else wr_inf_d = wr_inf_q - 1'b1;
            end
            default: ;
        endcase

        rd_beats_upd = sat_add(rd_beats_q, CntWidth'(rd_beat_i));
        wr_beats_upd = sat_add(wr_beats_q, CntWidth'(wr_beat_i));
        rd_txns_upd  = sat_add(rd_txns_q, CntWidth'(rd_last_i));
        // Latency integral uses the occupancy before this cycle's events.
        rd_lat_upd   = sat_add(rd_lat_q, CntWidth'(rd_inf_q));
        max_inf_upd  = (rd_inf_d > max_inf_q) ? rd_inf_d : max_inf_q;

        ovf_evt = run_i & (rd_beats_upd[CntWidth] | wr_beats_upd[CntWidth] |
                           rd_txns_upd[CntWidth] | rd_lat_upd[CntWidth]);

        rd_beats_d = rd_beats_q;
        wr_beats_d = wr_beats_q;
        rd_txns_d  = rd_txns_q;
        rd_lat_d   = rd_lat_q;
        max_inf_d  = max_inf_q;
        if (clr_i || snap_i) begin
            rd_beats_d = '0;
            wr_beats_d = '0;
            rd_txns_d  = '0;
            rd_lat_d   = '0;
            max_inf_d  = '0;
        end else if (run_i) begin
            rd_beats_d = rd_beats_upd[CntWidth-1:0];
            wr_beats_d = wr_beats_upd[CntWidth-1:0];
            rd_txns_d  = rd_txns_upd[CntWidth-1:0];
            rd_lat_d   = rd_lat_upd[CntWidth-1:0];
            max_inf_d  = max_inf_upd;
        end

        s_rd_beats_d = s_rd_beats_q;
        s_wr_beats_d = s_wr_beats_q;
        s_rd_txns_d  = s_rd_txns_q;
        s_rd_lat_d   = s_rd_lat_q;
        s_max_inf_d  = s_max_inf_q;
        if (snap_i) begin
            s_rd_beats_d = rd_beats_upd[CntWidth-1:0];
            s_wr_beats_d = wr_beats_upd[CntWidth-1:0];
            s_rd_txns_d  = rd_txns_upd[CntWidth-1:0];
            s_rd_lat_d   = rd_lat_upd[CntWidth-1:0];
            s_max_inf_d  = max_inf_upd;
        end

        overflow_d = flag_clr_i ? 1'b0 : (overflow_q | ovf_evt);
        error_d    = flag_clr_i ? 1'b0 : (error_q | rd_err | wr_err);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_inf_q     <= '0;
            wr_inf_q     <= '0;
            rd_beats_q   <= '0;
            wr_beats_q   <= '0;
            rd_txns_q    <= '0;
            rd_lat_q     <= '0;
            max_inf_q    <= '0;
            s_rd_beats_q <= '0;
            s_wr_beats_q <= '0;
            s_rd_txns_q  <= '0;
            s_rd_lat_q   <= '0;
            s_max_inf_q  <= '0;
            overflow_q   <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            rd_inf_q     <= rd_inf_d;
            wr_inf_q     <= wr_inf_d;
            rd_beats_q   <= rd_beats_d;
            wr_beats_q   <= wr_beats_d;
            rd_txns_q    <= rd_txns_d;
            rd_lat_q     <= rd_lat_d;
            max_inf_q    <= max_inf_d;
            s_rd_beats_q <= s_rd_beats_d;
            s_wr_beats_q <= s_wr_beats_d;
            s_rd_txns_q  <= s_rd_txns_d;
            s_rd_lat_q   <= s_rd_lat_d;
            s_max_inf_q  <= s_max_inf_d;
            overflow_q   <= overflow_d;
            error_q      <= error_d;
        end
    end

    assign snap_rd_beats_o   = s_rd_beats_q;
    assign snap_wr_beats_o   = s_wr_beats_q;
    assign snap_rd_txns_o    = s_rd_txns_q;
    assign snap_rd_lat_sum_o = s_rd_lat_q;
    assign snap_max_rd_inf_o = s_max_inf_q;
    assign overflow_o        = overflow_q;
    assign error_o           = error_q;

endmodule

// File: rtl/floo_perf_monitor.sv
// Windowed multi-port AXI traffic monitor: FSM, window counter, snapshot mux.
// Ports: start/stop/continuous/window_len control, per-port handshake events,
// sel_i snapshot select; busy/snap_valid/window_idx status, sticky flags.
module floo_perf_monitor
    import floo_pkg::*;
#(
    parameter int unsigned NumPorts    = DefNumPorts,
    parameter int unsigned CntWidth    = DefCntWidth,
    parameter int unsigned WindowWidth = DefWindowWidth,
    parameter int unsigned MaxInFlight = DefMaxInFlight,
    localparam int unsigned InfWidth   = $clog2(MaxInFlight + 1),
    localparam int unsigned SelWidth   = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic                   continuous_i,
    input  logic [WindowWidth-1:0] window_len_i,
    input  logic [NumPorts-1:0]    rd_req_i,
    input  logic [NumPorts-1:0]    rd_beat_i,
    input  logic [NumPorts-1:0]    rd_last_i,
    input  logic [NumPorts-1:0]    wr_req_i,
    input  logic [NumPorts-1:0]    wr_beat_i,
    input  logic [NumPorts-1:0]    wr_done_i,
    input  logic [SelWidth-1:0]    sel_i,
    output logic                   busy_o,
    output logic                   snap_valid_o,
    output logic [WindowWidth-1:0] window_idx_o,
    output logic [CntWidth-1:0]    snap_rd_beats_o,
    output logic [CntWidth-1:0]    snap_wr_beats_o,
    output logic [CntWidth-1:0]    snap_rd_txns_o,
    output logic [CntWidth-1:0]    snap_rd_lat_sum_o,
    output logic [InfWidth-1:0]    snap_max_rd_inflight_o,
    output logic [NumPorts-1:0]    overflow_o,
    output logic [NumPorts-1:0]    error_o
);

    perf_state_e            state_q, state_d;
    logic [WindowWidth-1:0] win_cnt_q, win_cnt_d;
    logic [WindowWidth-1:0] win_len_q, win_len_d;
    logic                   cont_q, cont_d;
    logic [WindowWidth-1:0] win_idx_q, win_idx_d;
    logic                   snap_valid_q, snap_valid_d;

    logic start_ok, boundary, run, cnt_clr;

    logic [CntWidth-1:0] rd_beats_a [NumPorts];
    logic [CntWidth-1:0] wr_beats_a [NumPorts];
    logic [CntWidth-1:0] rd_txns_a  [NumPorts];
    logic [CntWidth-1:0] rd_lat_a   [NumPorts];
    logic [InfWidth-1:0] max_inf_a  [NumPorts];

    always_comb begin
        // stop_i dominates every other control input.
        start_ok = start_i && !stop_i && (state_q == PerfIdle) &&
                   (window_len_i != '0);
        run      = (state_q == PerfRun) && !stop_i;
        boundary = run && (win_cnt_q == '0);
        cnt_clr  = start_ok || stop_i;

        state_d      = state_q;
        win_cnt_d    = win_cnt_q;
        win_len_d    = win_len_q;
        cont_d       = cont_q;
        win_idx_d    = win_idx_q;
        snap_valid_d = boundary;

        if (stop_i) begin
            state_d = PerfIdle;
        end else begin
            unique case (state_q)
                PerfIdle: begin
                    if (start_ok) begin
                        state_d   = PerfRun;
                        win_cnt_d = window_len_i - 1'b1;
                        win_len_d = window_len_i;
                        cont_d    = continuous_i;
                        win_idx_d = '0;
                    end
                end
                PerfRun: begin
                    if (win_cnt_q == '0) begin
                        win_idx_d = win_idx_q + 1'b1;
                        if (cont_q) win_cnt_d = win_len_q - 1'b1;
                        else state_d = PerfHold;
                    end else begin
                        win_cnt_d = win_cnt_q - 1'b1;
                    end
                end
                PerfHold: state_d = PerfIdle;
                default:  state_d = PerfIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= PerfIdle;
            win_cnt_q    <= '0;
            win_len_q    <= '0;
            cont_q       <= 1'b0;
            win_idx_q    <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_cnt_q    <= win_cnt_d;
            win_len_q    <= win_len_d;
            cont_q       <= cont_d;
            win_idx_q    <= win_idx_d;
            snap_valid_q <= snap_valid_d;
        end
    end

    for (genvar p = 0; p < NumPorts; p++) begin : g_port
        floo_perf_port_cnt #(
            .CntWidth    (CntWidth),
            .MaxInFlight (MaxInFlight)
        ) i_cnt (
            .clk_i             (clk_i),
            .rst_i             (rst_i),
            .run_i             (run),
            .clr_i             (cnt_clr),
            .flag_clr_i        (start_ok),
            .snap_i            (boundary),
            .rd_req_i          (rd_req_i[p]),
            .rd_beat_i         (rd_beat_i[p]),
            .rd_last_i         (rd_last_i[p]),
            .wr_req_i          (wr_req_i[p]),
            .wr_beat_i         (wr_beat_i[p]),
            .wr_done_i         (wr_done_i[p]),
            .snap_rd_beats_o   (rd_beats_a[p]),
            .snap_wr_beats_o   (wr_beats_a[p]),
            .snap_rd_txns_o    (rd_txns_a[p]),
            .snap_rd_lat_sum_o (rd_lat_a[p]),
            .snap_max_rd_inf_o (max_inf_a[p]),
            .overflow_o        (overflow_o[p]),
            .error_o           (error_o[p])
        );
    end

    // Unmatched select codes fall through to zero.
    always_comb begin
        snap_rd_beats_o        = '0;
        snap_wr_beats_o        = '0;
        snap_rd_txns_o         = '0;
        snap_rd_lat_sum_o      = '0;
        snap_max_rd_inflight_o = '0;
        for (int p = 0; p < NumPorts; p++) begin
            if (sel_i == SelWidth'(p)) begin
                snap_rd_beats_o        = rd_beats_a[p];
                snap_wr_beats_o        = wr_beats_a[p];
                snap_rd_txns_o         = rd_txns_a[p];
                snap_rd_lat_sum_o      = rd_lat_a[p];
                snap_max_rd_inflight_o = max_inf_a[p];
            end
        end
    end

    assign busy_o       = (state_q == PerfRun);
    assign snap_valid_o = snap_valid_q;
    assign window_idx_o = win_idx_q;

endmodule

// File: tb/tb_floo_perf_monitor.sv
// Self-checking bench for floo_perf_monitor: directed scenarios plus
// randomized traffic against an integer reference model.
module tb_floo_perf_monitor;

    localparam int NP   = 3;
    localparam int CW   = 8;
    localparam int WW   = 10;
    localparam int MI   = 7;
    localparam int IW   = 3;
    localparam int SW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          cont = 1'b0;
    logic [WW-1:0] wlen = '0;
    logic [NP-1:0] rd_req = '0, rd_beat = '0, rd_last = '0;
    logic [NP-1:0] wr_req = '0, wr_beat = '0, wr_done = '0;
    logic [SW-1:0] sel = '0;
    logic          busy, sval;
    logic [WW-1:0] widx;
    logic [CW-1:0] o_rb, o_wb, o_rt, o_ls;
    logic [IW-1:0] o_mx;
    logic [NP-1:0] ovf, err;

    floo_perf_monitor #(
        .NumPorts    (NP),
        .CntWidth    (CW),
        .WindowWidth (WW),
        .MaxInFlight (MI)
    ) dut (
        .clk_i                  (clk),
        .rst_i                  (rst),
        .start_i                (start),
        .stop_i                 (stop),
        .continuous_i           (cont),
        .window_len_i           (wlen),
        .rd_req_i               (rd_req),
        .rd_beat_i              (rd_beat),
        .rd_last_i              (rd_last),
        .wr_req_i               (wr_req),
        .wr_beat_i              (wr_beat),
        .wr_done_i              (wr_done),
        .sel_i                  (sel),
        .busy_o                 (busy),
        .snap_valid_o           (sval),
        .window_idx_o           (widx),
        .snap_rd_beats_o        (o_rb),
        .snap_wr_beats_o        (o_wb),
        .snap_rd_txns_o         (o_rt),
        .snap_rd_lat_sum_o      (o_ls),
        .snap_max_rd_inflight_o (o_mx),
        .overflow_o             (ovf),
        .error_o                (err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: 0 idle, 1 measuring, 2 hold.
    int m_st = 0, m_left = 0, m_len = 0, m_cont = 0, m_idx = 0, m_valid = 0;
    int rinf[NP], winf[NP];
    int a_rb[NP], a_wb[NP], a_rt[NP], a_ls[NP], a_mx[NP];
    int s_rb[NP], s_wb[NP], s_rt[NP], s_ls[NP], s_mx[NP];
    bit m_ovf[NP], m_err[NP];

    function automatic int clampc(int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic zero_model();
        m_st = 0; m_left = 0; m_len = 0; m_cont = 0; m_idx = 0; m_valid = 0;
        for (int p = 0; p < NP; p++) begin
            rinf[p] = 0; winf[p] = 0;
            a_rb[p] = 0; a_wb[p] = 0; a_rt[p] = 0; a_ls[p] = 0; a_mx[p] = 0;
            s_rb[p] = 0; s_wb[p] = 0; s_rt[p] = 0; s_ls[p] = 0; s_mx[p] = 0;
            m_ovf[p] = 0; m_err[p] = 0;
        end
    endtask

    task automatic model_step();
        bit go, bnd, meas;
        int rn, wn;
        if (rst) begin
            zero_model();
            return;
        end
        go   = start && !stop && m_st == 0 && wlen != 0;
        meas = m_st == 1 && !stop;
        bnd  = meas && m_left == 0;
        for (int p = 0; p < NP; p++) begin
            rn = rinf[p] + int'(rd_req[p]) - int'(rd_last[p]);
            wn = winf[p] + int'(wr_req[p]) - int'(wr_done[p]);
            if (rn < 0 || rn > MI) m_err[p] = 1;
            if (wn < 0 || wn > MI) m_err[p] = 1;
            rn = (rn < 0) ? 0 : (rn > MI) ? MI : rn;
            wn = (wn < 0) ? 0 : (wn > MI) ? MI : wn;
            if (meas) begin
                if (a_rb[p] + int'(rd_beat[p]) > CMAX) m_ovf[p] = 1;
                if (a_wb[p] + int'(wr_beat[p]) > CMAX) m_ovf[p] = 1;
                if (a_rt[p] + int'(rd_last[p]) > CMAX) m_ovf[p] = 1;
                if (a_ls[p] + rinf[p] > CMAX) m_ovf[p] = 1;
                a_rb[p] = clampc(a_rb[p] + int'(rd_beat[p]));
                a_wb[p] = clampc(a_wb[p] + int'(wr_beat[p]));
                a_rt[p] = clampc(a_rt[p] + int'(rd_last[p]));
                a_ls[p] = clampc(a_ls[p] + rinf[p]);
                if (rn > a_mx[p]) a_mx[p] = rn;
            end
            if (bnd) begin
                s_rb[p] = a_rb[p]; s_wb[p] = a_wb[p]; s_rt[p] = a_rt[p];
                s_ls[p] = a_ls[p]; s_mx[p] = a_mx[p];
            end
            if (bnd || go || stop) begin
                a_rb[p] = 0; a_wb[p] = 0; a_rt[p] = 0; a_ls[p] = 0; a_mx[p] = 0;
            end
            if (go) begin
                m_ovf[p] = 0; m_err[p] = 0;
            end
            rinf[p] = rn;
            winf[p] = wn;
        end
        m_valid = bnd;
        if (bnd) m_idx = (m_idx + 1) % (1 << WW);
        if (go) m_idx = 0;
        if (stop) m_st = 0;
        else if (go) begin
            m_st = 1; m_left = int'(wlen) - 1; m_len = int'(wlen); m_cont = cont;
        end else if (m_st == 1) begin
            if (m_left == 0) begin
                if (m_cont != 0) m_left = m_len - 1;
                else m_st = 2;
            end else m_left--;
        end else if (m_st == 2) m_st = 0;
    endtask

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        int s;
        logic [NP-1:0] eo, ee;
        s = int'(sel);
        for (int p = 0; p < NP; p++) begin
            eo[p] = m_ovf[p];
            ee[p] = m_err[p];
        end
        chk("busy", 64'(busy), 64'(m_st == 1));
        chk("snap_valid", 64'(sval), 64'(m_valid));
        chk("window_idx", 64'(widx), 64'(m_idx));
        chk("overflow", 64'(ovf), 64'(eo));
        chk("error", 64'(err), 64'(ee));
        chk("rd_beats", 64'(o_rb), (s < NP) ? 64'(s_rb[s]) : 64'd0);
        chk("wr_beats", 64'(o_wb), (s < NP) ? 64'(s_wb[s]) : 64'd0);
        chk("rd_txns", 64'(o_rt), (s < NP) ? 64'(s_rt[s]) : 64'd0);
        chk("rd_lat_sum", 64'(o_ls), (s < NP) ? 64'(s_ls[s]) : 64'd0);
        chk("max_inf", 64'(o_mx), (s < NP) ? 64'(s_mx[s]) : 64'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic clr_ev();
        rd_req = '0; rd_beat = '0; rd_last = '0;
        wr_req = '0; wr_beat = '0; wr_done = '0;
    endtask

    task automatic start_win(input int len, input bit c);
        start = 1'b1;
        wlen  = WW'(len);
        cont  = c;
        tick();
        start = 1'b0;
    endtask

    int pulses;

    initial begin
        zero_model();
        // Reset, then idle traffic without a start.
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rd_beat = NP'($urandom);
            wr_beat = NP'($urandom);
            sel     = SW'($urandom);
            tick();
            chk("idle_valid", 64'(sval), 64'd0);
        end
        clr_ev();

        // Single window, len 10: AR at 0, beats 2..5, last at 5.
        sel = 0;
        start_win(10, 1'b0);
        for (int k = 0; k < 10; k++) begin
            clr_ev();
            rd_req[0]  = (k == 0);
            rd_beat[0] = (k >= 2 && k <= 5);
            rd_last[0] = (k == 5);
            tick();
        end
        clr_ev();
        chk("sw_valid", 64'(sval), 64'd1);
        chk("sw_rd_beats", 64'(o_rb), 64'd4);
        chk("sw_rd_txns", 64'(o_rt), 64'd1);
        chk("sw_lat_sum", 64'(o_ls), 64'd5);
        chk("sw_max_inf", 64'(o_mx), 64'd1);
        chk("sw_idx", 64'(widx), 64'd1);
        tick();
        chk("sw_busy_after", 64'(busy), 64'd0);
        chk("sw_valid_after", 64'(sval), 64'd0);

        // Continuous, len 4, write beat every cycle on port 2.
        sel = 2;
        start_win(4, 1'b1);
        for (int w = 1; w <= 3; w++) begin
            wr_beat[2] = 1'b1;
            repeat (3) begin
                tick();
                chk("ct_gap", 64'(sval), 64'd0);
            end
            tick();
            chk("ct_valid", 64'(sval), 64'd1);
            chk("ct_wr_beats", 64'(o_wb), 64'd4);
            chk("ct_idx", 64'(widx), 64'(w));
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        clr_ev();
        chk("ct_stop_busy", 64'(busy), 64'd0);
        chk("ct_stop_keep", 64'(o_wb), 64'd4);

        // Cross-window read: AR at cycle 2, last at cycle 10, len 8.
        sel = 1;
        start_win(8, 1'b1);
        for (int k = 0; k < 16; k++) begin
            clr_ev();
            rd_req[1]  = (k == 2);
            rd_beat[1] = (k == 10);
            rd_last[1] = (k == 10);
            tick();
            if (k == 7) begin
                chk("xw0_txns", 64'(o_rt), 64'd0);
                chk("xw0_lat", 64'(o_ls), 64'd5);
            end
            if (k == 15) begin
                chk("xw1_txns", 64'(o_rt), 64'd1);
                chk("xw1_lat", 64'(o_ls), 64'd3);
            end
        end
        clr_ev();
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Saturation plus in-flight underflow on port 0.
        start_win(300, 1'b0);
        for (int k = 0; k < 300; k++) begin
            clr_ev();
            rd_beat[1] = 1'b1;
            rd_last[0] = (k == 0);
            rd_beat[0] = (k == 0);
            tick();
            if (k == 0) chk("uf_err", 64'(err), 64'b001);
        end
        clr_ev();
        chk("sat_rd_beats", 64'(o_rb), 64'(CMAX));
        chk("sat_ovf", 64'(ovf), 64'b010);
        tick();

        // start and stop together: stop wins.
        start = 1'b1; stop = 1'b1; wlen = 5;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("ss_busy", 64'(busy), 64'd0);

        // stop mid-window: no pulse, snapshot retained.
        start_win(20, 1'b0);
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            rd_beat[2] = 1'b1;
            stop = (k == 5);
            tick();
            if (sval) pulses++;
        end
        stop = 1'b0;
        clr_ev();
        chk("stop_pulses", 64'(pulses), 64'd0);
        chk("stop_keep", 64'(o_rb), 64'(CMAX));

        // Synchronous reset mid-run.
        start_win(20, 1'b1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_snap", 64'(o_rb), 64'd0);

        // Randomized traffic and control.
        for (int i = 0; i < 1500; i++) begin
            for (int p = 0; p < NP; p++) begin
                rd_req[p]  = ($urandom_range(0, 2) == 0);
                rd_last[p] = ($urandom_range(0, 3) == 0);
                rd_beat[p] = rd_last[p] | ($urandom_range(0, 1) == 0);
                wr_req[p]  = ($urandom_range(0, 2) == 0);
                wr_done[p] = ($urandom_range(0, 3) == 0);
                wr_beat[p] = ($urandom_range(0, 1) == 0);
            end
            start = ($urandom_range(0, 15) == 0);
            stop  = ($urandom_range(0, 79) == 0);
            cont  = $urandom_range(0, 1) == 1;
            wlen  = WW'($urandom_range(0, 12));
            rst   = ($urandom_range(0, 399) == 0);
            sel   = SW'($urandom_range(0, 3));
            tick();
        end
        clr_ev();
        start = 1'b0; stop = 1'b0; rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
